// File: rtl/vga_timing_generator.sv
// VGA raster timing: free-running h/v position counters advanced by a pixel tick,
// with sync and blanking flags delayed to line up with frame-buffer read latency.
module vga_timing_generator #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int PIPE_DELAY = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  output logic       pixel_req,
  output logic       frame_start,
  output logic [9:0] h_count,
  output logic [9:0] v_count,
  output logic       hsync_n,
  output logic       vsync_n,
  output logic       blank_n
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [9:0] h_q, h_d;
  logic [9:0] v_q, v_d;
  logic       active;
  logic       hs_raw;
  logic       vs_raw;

  logic [PIPE_DELAY-1:0] hs_pipe_q, hs_pipe_d;
  logic [PIPE_DELAY-1:0] vs_pipe_q, vs_pipe_d;
  logic [PIPE_DELAY-1:0] act_pipe_q, act_pipe_d;

  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (h_q == H_LAST) begin
      h_d = '0;
      v_d = (v_q == V_LAST) ? '0 : v_q + 10'd1;
    end else begin
      h_d = h_q + 10'd1;
    end
  end

  assign active = (h_q < H_ACT) && (v_q < V_ACT);
  assign hs_raw = !((h_q >= HS_START) && (h_q < HS_END));
  assign vs_raw = !((v_q >= VS_START) && (v_q < VS_END));

  always_comb begin
    hs_pipe_d     = hs_pipe_q;
    vs_pipe_d     = vs_pipe_q;
    act_pipe_d    = act_pipe_q;
    hs_pipe_d[0]  = hs_raw;
    vs_pipe_d[0]  = vs_raw;
    act_pipe_d[0] = active;
    for (int i = 1; i < PIPE_DELAY; i++) begin
      hs_pipe_d[i]  = hs_pipe_q[i-1];
      vs_pipe_d[i]  = vs_pipe_q[i-1];
      act_pipe_d[i] = act_pipe_q[i-1];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      h_q        <= '0;
      v_q        <= '0;
      hs_pipe_q  <= '1;
      vs_pipe_q  <= '1;
      act_pipe_q <= '0;
    end else if (enable) begin
      h_q        <= h_d;
      v_q        <= v_d;
      hs_pipe_q  <= hs_pipe_d;
      vs_pipe_q  <= vs_pipe_d;
      act_pipe_q <= act_pipe_d;
    end
  end

  // Counters sit at (0,0) during reset, so the strobes must be gated by reset explicitly.
  assign pixel_req   = reset & enable & active;
  assign frame_start = reset & enable & (h_q == 10'd0) & (v_q == 10'd0);

  assign h_count = h_q;
  assign v_count = v_q;
  assign hsync_n = hs_pipe_q[PIPE_DELAY-1];
  assign vsync_n = vs_pipe_q[PIPE_DELAY-1];
  assign blank_n = act_pipe_q[PIPE_DELAY-1];

endmodule

// File: tb/tb_vga_timing_generator.sv
// Scoreboard bench: expected outputs derive from the tick count since reset and
// the raster geometry; a negedge monitor pops and compares every cycle.
module tb_vga_timing_generator;

  localparam int HA = 16, HF = 4, HS = 6, HB = 6;
  localparam int VA = 10, VF = 2, VS = 2, VB = 3;
  localparam int PD = 2;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b0;
  logic       pixel_req, frame_start, hsync_n, vsync_n, blank_n;
  logic [9:0] h_count, v_count;

  vga_timing_generator #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .PIPE_DELAY(PD)
  ) dut (
    .clock(clock), .reset(reset), .enable(enable),
    .pixel_req(pixel_req), .frame_start(frame_start),
    .h_count(h_count), .v_count(v_count),
    .hsync_n(hsync_n), .vsync_n(vsync_n), .blank_n(blank_n)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [9:0] h;
    logic [9:0] v;
    logic       pr;
    logic       fs;
    logic       hs;
    logic       vs;
    logic       bl;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   n      = 0;   // ticks taken since last reset release
  bit   last_en = 1'b0;

  function automatic exp_t model(int ticks, bit en, bit rst_n);
    exp_t e;
    int   p, h, v, p2, h2, v2;
    e = '{h: 10'd0, v: 10'd0, pr: 1'b0, fs: 1'b0, hs: 1'b1, vs: 1'b1, bl: 1'b0};
    if (!rst_n) return e;
    p = ticks % FT;
    h = p % HT;
    v = p / HT;
    e.h  = 10'(h);
    e.v  = 10'(v);
    e.pr = en && (h < HA) && (v < VA);
    e.fs = en && (p == 0);
    if (ticks >= PD) begin
      p2 = (ticks - PD) % FT;
      h2 = p2 % HT;
      v2 = p2 / HT;
      e.hs = !((h2 >= HA + HF) && (h2 < HA + HF + HS));
      e.vs = !((v2 >= VA + VF) && (v2 < VA + VF + VS));
      e.bl = (h2 < HA) && (v2 < VA);
    end
    return e;
  endfunction

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // One clock of stimulus: account for the tick just taken, then drive and predict.
  task automatic cycle(input bit en, input bit rst_n);
    @(posedge clock);
    if (last_en && reset) n++;
    #1;
    reset  = rst_n;
    if (!rst_n) n = 0;
    enable  = en;
    last_en = en;
    q.push_back(model(n, en, rst_n));
  endtask

  // Monitor: per-cycle scoreboard plus run-length and frame-level measurements.
  int  frame_ticks = 0, frame_pix = 0, hrun = 0, vrun = 0;
  bit  frame_seen = 1'b0;

  always @(negedge clock) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("h_count", int'(h_count), int'(e.h));
      chk("v_count", int'(v_count), int'(e.v));
      chk("pixel_req", int'(pixel_req), int'(e.pr));
      chk("frame_start", int'(frame_start), int'(e.fs));
      chk("hsync_n", int'(hsync_n), int'(e.hs));
      chk("vsync_n", int'(vsync_n), int'(e.vs));
      chk("blank_n", int'(blank_n), int'(e.bl));
    end
    if (!reset) begin
      frame_seen = 1'b0; frame_ticks = 0; frame_pix = 0; hrun = 0; vrun = 0;
    end else if (enable) begin
      if (frame_start) begin
        if (frame_seen) begin
          chk("frame_ticks", frame_ticks, FT);
          chk("frame_pixels", frame_pix, HA * VA);
        end
        frame_seen = 1'b1; frame_ticks = 0; frame_pix = 0;
      end
      frame_ticks++;
      if (pixel_req) frame_pix++;
      if (!hsync_n) hrun++;
      else if (hrun != 0) begin chk("hsync_width", hrun, HS); hrun = 0; end
      if (!vsync_n) vrun++;
      else if (vrun != 0) begin chk("vsync_width", vrun, VS * HT); vrun = 0; end
    end
  end

  initial begin
    int guard;
    // Reset held with enable high: strobes must stay low.
    repeat (4) cycle(1'b1, 1'b0);
    // Continuous ticks for a bit over two frames.
    repeat (2 * FT + 40) cycle(1'b1, 1'b1);
    // Random tick pattern.
    repeat (3000) cycle(($urandom_range(0, 9) < 7), 1'b1);
    // Walk to a mid-frame position, then freeze for 50 clocks.
    guard = 0;
    while (!(((n % FT) % HT == 10) && ((n % FT) / HT == 5)) && guard < 2 * FT) begin
      cycle(1'b1, 1'b1);
      guard++;
    end
    chk("reach_freeze_point", int'(guard < 2 * FT), 1);
    repeat (50) cycle(1'b0, 1'b1);
    repeat (5) cycle(1'b1, 1'b1);
    // Walk to a late position and pulse reset mid-frame.
    guard = 0;
    while (!(((n % FT) % HT == HT - 4) && ((n % FT) / HT == 8)) && guard < 2 * FT) begin
      cycle(1'b1, 1'b1);
      guard++;
    end
    chk("reach_reset_point", int'(guard < 2 * FT), 1);
    repeat (2) cycle(1'b1, 1'b0);
    repeat (FT + 20) cycle(1'b1, 1'b1);
    repeat (1500) cycle(($urandom_range(0, 3) != 0), 1'b1);
    cycle(1'b1, 1'b0);
    repeat (FT + 5) cycle(1'b1, 1'b1);
    @(negedge clock);
    @(negedge clock);
    chk("scoreboard_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
